sd_cmd_engine: RTL and testbench

SD-bus command-line sequencer for the `sdhc` controller. It does four things:
- generates `sd_clk`;
- serializes a 48-bit command frame with CRC7 onto CMD;
- waits for and deserializes a 48-bit response;
- reports completion and errors to the `sdhc` register/DMA logic.

`sdhc` instantiates this block and owns the `sd_cmd` inout pad, driving it from `sd_cmd_out`/`sd_cmd_oe` and feeding back `sd_cmd_in`.

---
 rtl/sd_cmd_engine.sv | 218 +++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD-bus CMD-line sequencer. Generates sd_clk, sends a
// 48-bit command frame with CRC7, optionally receives and checks a 48-bit
// response, then holds Ncc idle clocks before signalling completion.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   cmd_start, cmd_index, cmd_arg,    command request and its fields
//   resp_type                         (0 none, 1/3 checked, 2 unchecked)
//   cmd_busy, cmd_done                busy level and one-cycle completion pulse
//   resp_index, resp_arg              captured response fields
//   err_timeout, err_crc, err_index   response error flags
//   sd_clk                            SD bus clock
//   sd_cmd_out, sd_cmd_oe, sd_cmd_in  CMD pad output, enable, input
module sd_cmd_engine #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [1:0]  resp_type,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        err_timeout,
    output logic        err_crc,
    output logic        err_index,
    output logic        sd_clk,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_in
);

    localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TO_W    = $clog2(RESP_TIMEOUT + 1);
    localparam int unsigned FRAME_W = 48;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_GAP,
        S_DONE
    } state_t;

    // CRC7, polynomial x^7 + x^3 + 1, initial value 0, MSB first
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end
        end
        return crc;
    endfunction

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [FRAME_W-1:0] tx_shift;
    logic [5:0]         bit_cnt;
    logic [46:0]        rx_shift;
    logic [5:0]         rx_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [2:0]         gap_cnt;
    logic [5:0]         lat_index;
    logic [1:0]         lat_type;

    logic               div_tick;
    logic               fall_tick;
    logic               rise_tick;
    logic [FRAME_W-1:0] rx_frame_c;
    logic [6:0]         rx_crc_c;
    logic [39:0]        tx_head_c;

    assign div_tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_tick  = div_tick & sd_clk;
    assign rise_tick  = div_tick & ~sd_clk;
    // Full response as it stands once the current CMD sample is shifted in
    assign rx_frame_c = {rx_shift, sd_cmd_in};
    assign rx_crc_c   = crc7(rx_frame_c[47:8]);
    assign tx_head_c  = {2'b01, cmd_index, cmd_arg};

    // Clock divider plus command sequencer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            sd_clk      <= 1'b0;
            sd_cmd_out  <= 1'b1;
            sd_cmd_oe   <= 1'b0;
            cmd_busy    <= 1'b0;
            cmd_done    <= 1'b0;
            resp_index  <= '0;
            resp_arg    <= '0;
            err_timeout <= 1'b0;
            err_crc     <= 1'b0;
            err_index   <= 1'b0;
            tx_shift    <= '1;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_cnt      <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            lat_index   <= '0;
            lat_type    <= '0;
        end else begin
            if (div_tick) begin
                div_cnt <= '0;
                sd_clk  <= ~sd_clk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            cmd_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        lat_index   <= cmd_index;
                        lat_type    <= resp_type;
                        tx_shift    <= {tx_head_c, crc7(tx_head_c), 1'b1};
                        bit_cnt     <= '0;
                        resp_index  <= '0;
                        resp_arg    <= '0;
                        err_timeout <= 1'b0;
                        err_crc     <= 1'b0;
                        err_index   <= 1'b0;
                        cmd_busy    <= 1'b1;
                        state       <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (fall_tick) begin
                        if (bit_cnt != 6'(FRAME_W)) begin
                            sd_cmd_out <= tx_shift[FRAME_W-1];
                            sd_cmd_oe  <= 1'b1;
                            tx_shift   <= {tx_shift[FRAME_W-2:0], 1'b1};
                            bit_cnt    <= bit_cnt + 6'd1;
                        end else begin
                            // End bit has had its full period; release the line
                            sd_cmd_out <= 1'b1;
                            sd_cmd_oe  <= 1'b0;
                            to_cnt     <= '0;
                            gap_cnt    <= '0;
                            state      <= (lat_type == 2'd0) ? S_GAP : S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    // A start bit on the last allowed tick wins over the timeout
                    if (rise_tick) begin
                        if (!sd_cmd_in) begin
                            rx_shift <= '0;
                            rx_cnt   <= 6'd1;
                            state    <= S_RECV;
                        end else if (to_cnt == TO_W'(RESP_TIMEOUT - 1)) begin
                            err_timeout <= 1'b1;
                            state       <= S_GAP;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end

                S_RECV: begin
                    if (rise_tick) begin
                        if (rx_cnt == 6'(FRAME_W - 1)) begin
                            resp_index <= rx_frame_c[45:40];
                            resp_arg   <= rx_frame_c[39:8];
                            if (lat_type != 2'd2) begin
                                err_crc   <= rx_frame_c[46] | ~rx_frame_c[0] |
                                             (rx_frame_c[7:1] != rx_crc_c);
                                err_index <= (rx_frame_c[45:40] != lat_index);
                            end
                            state <= S_GAP;
                        end else begin
                            rx_shift <= rx_frame_c[46:0];
                            rx_cnt   <= rx_cnt + 6'd1;
                        end
                    end
                end

                S_GAP: begin
                    // Ncc: eight idle clocks with CMD released
                    if (fall_tick) begin
                        if (gap_cnt == 3'd7) begin
                            cmd_done <= 1'b1;
                            cmd_busy <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            gap_cnt <= gap_cnt + 3'd1;
                        end
                    end
                end

                S_DONE: begin
                    // Swallows any start coinciding with cmd_done
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: captures the CMD frame on sd_clk rising
// edges, answers with a scripted response, and checks fields, flags, timing.
module tb_sd_cmd_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [1:0]  resp_type;
    logic        cmd_busy;
    logic        cmd_done;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        err_timeout;
    logic        err_crc;
    logic        err_index;
    logic        sd_clk;
    logic        sd_cmd_out;
    logic        sd_cmd_oe;
    logic        sd_cmd_in;

    logic        line;
    logic        resp_en;
    logic [47:0] resp_frame;
    logic [47:0] tx_frame;
    int          tx_total;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign sd_cmd_in = sd_cmd_oe ? sd_cmd_out : line;

    sd_cmd_engine #(.CLK_DIV(4), .RESP_TIMEOUT(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_start   (cmd_start),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .resp_type   (resp_type),
        .cmd_busy    (cmd_busy),
        .cmd_done    (cmd_done),
        .resp_index  (resp_index),
        .resp_arg    (resp_arg),
        .err_timeout (err_timeout),
        .err_crc     (err_crc),
        .err_index   (err_index),
        .sd_clk      (sd_clk),
        .sd_cmd_out  (sd_cmd_out),
        .sd_cmd_oe   (sd_cmd_oe),
        .sd_cmd_in   (sd_cmd_in)
    );

    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
            else             c = {c[5:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [47:0] resp_of(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b00, idx, arg};
        return {h, ref_crc7(h), 1'b1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmit monitor: one sample per bit, mid-period
    initial begin
        tx_total = 0;
        tx_frame = '0;
        forever begin
            @(posedge sd_clk);
            #1;
            if (sd_cmd_oe === 1'b1) begin
                tx_frame = {tx_frame[46:0], sd_cmd_out};
                tx_total++;
            end
        end
    end

    // Card model: answers two bit periods after the host releases CMD
    initial begin
        line = 1'b1;
        forever begin
            @(negedge sd_cmd_oe);
            #1;
            if (resp_en) begin
                repeat (2) @(negedge sd_clk);
                for (int i = 47; i >= 0; i--) begin
                    #1 line = resp_frame[i];
                    @(negedge sd_clk);
                end
                #1 line = 1'b1;
            end
        end
    end

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
        @(negedge clk);
        cmd_index = idx;
        cmd_arg   = arg;
        resp_type = rt;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cmd_done !== 1'b1 && n < 3000);
        check({tag, "_done"}, 64'(cmd_done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(cmd_busy), 64'd0);
    endtask

    initial begin
        int n;
        int base;
        int w;
        logic seen;

        rst_n      = 1'b0;
        cmd_start  = 1'b0;
        cmd_index  = '0;
        cmd_arg    = '0;
        resp_type  = '0;
        resp_en    = 1'b0;
        resp_frame = '1;
        repeat (5) @(negedge clk);
        check("rst_sd_clk", 64'(sd_clk), 64'd0);
        check("rst_oe", 64'(sd_cmd_oe), 64'd0);
        check("rst_out", 64'(sd_cmd_out), 64'd1);
        check("rst_busy_done", 64'({cmd_busy, cmd_done}), 64'd0);
        check("rst_resp", 64'({resp_index, resp_arg}), 64'd0);
        check("rst_errs", 64'({err_timeout, err_crc, err_index}), 64'd0);
        rst_n = 1'b1;

        // CMD0, no response
        base = tx_total;
        start_cmd(6'd0, 32'h0, 2'd0);
        check("cmd0_busy", 64'(cmd_busy), 64'd1);
        wait_done("cmd0", n);
        check("cmd0_frame", 64'(tx_frame), 64'h400000000095);
        check("cmd0_oe_bits", 64'(tx_total - base), 64'd48);
        check("cmd0_errs", 64'({err_timeout, err_crc, err_index}), 64'd0);
        check("cmd0_latency", 64'(n >= 449 && n <= 456), 64'd1);

        // Start coinciding with cmd_done is dropped; one cycle later it is taken
        cmd_index  = 6'd8;
        cmd_arg    = 32'h1AA;
        resp_type  = 2'd1;
        cmd_start  = 1'b1;
        resp_frame = 48'h08000001AA13;
        resp_en    = 1'b1;
        base       = tx_total;
        @(negedge clk);
        check("start_on_done_ignored", 64'(cmd_busy), 64'd0);
        @(negedge clk);
        cmd_start = 1'b0;
        check("start_after_done_taken", 64'(cmd_busy), 64'd1);
        wait_done("cmd8", n);
        check("cmd8_frame", 64'(tx_frame), 64'h48000001AA87);
        check("cmd8_oe_bits", 64'(tx_total - base), 64'd48);
        check("cmd8_resp_index", 64'(resp_index), 64'd8);
        check("cmd8_resp_arg", 64'(resp_arg), 64'h1AA);
        check("cmd8_errs", 64'({err_timeout, err_crc, err_index}), 64'd0);
        repeat (10) @(negedge clk);
        check("cmd8_resp_held", 64'({resp_index, resp_arg}), 64'({6'd8, 32'h1AA}));

        // R7 with CRC bit 0 flipped
        resp_frame = 48'h08000001AA11;
        start_cmd(6'd8, 32'h1AA, 2'd1);
        wait_done("badcrc", n);
        check("badcrc_errs", 64'({err_timeout, err_crc, err_index}), 64'b010);

        // R7 carrying index 9 with its own valid CRC
        resp_frame = resp_of(6'd9, 32'h1AA);
        start_cmd(6'd8, 32'h1AA, 2'd1);
        check("idx9_crc_cleared", 64'(err_crc), 64'd0);
        wait_done("idx9", n);
        check("idx9_resp_index", 64'(resp_index), 64'd9);
        check("idx9_errs", 64'({err_timeout, err_crc, err_index}), 64'b001);

        // Timeout, with a start pulse mid-command that must be ignored
        resp_en = 1'b0;
        base    = tx_total;
        start_cmd(6'd8, 32'h1AA, 2'd1);
        check("to_index_cleared", 64'(err_index), 64'd0);
        repeat (100) @(negedge clk);
        cmd_index = 6'h3F;
        cmd_arg   = 32'hFFFFFFFF;
        resp_type = 2'd0;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done("timeout", n);
        n = n + 101;
        check("timeout_frame", 64'(tx_frame), 64'h48000001AA87);
        check("timeout_oe_bits", 64'(tx_total - base), 64'd48);
        check("timeout_errs", 64'({err_timeout, err_crc, err_index}), 64'b100);
        check("timeout_latency", 64'(n >= 953 && n <= 960), 64'd1);

        // R3: fields captured raw, no checks
        resp_en    = 1'b1;
        resp_frame = 48'h3F80FF8000FF;
        start_cmd(6'd41, 32'h40FF8000, 2'd2);
        check("r3_timeout_cleared", 64'(err_timeout), 64'd0);
        wait_done("r3", n);
        check("r3_resp_index", 64'(resp_index), 64'h3F);
        check("r3_resp_arg", 64'(resp_arg), 64'h80FF8000);
        check("r3_errs", 64'({err_timeout, err_crc, err_index}), 64'd0);

        // Reset while bit 20 is on the line
        resp_en = 1'b0;
        base    = tx_total;
        start_cmd(6'd17, 32'h0, 2'd1);
        w = 0;
        while (tx_total - base < 20 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("rstmid_reached_bit20", 64'(tx_total - base >= 20), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_oe", 64'(sd_cmd_oe), 64'd0);
        check("rstmid_sd_clk", 64'(sd_clk), 64'd0);
        check("rstmid_busy", 64'(cmd_busy), 64'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cmd_done === 1'b1) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (cmd_done === 1'b1) seen = 1'b1;
        end
        check("rstmid_no_done", 64'(seen), 64'd0);

        // CMD17 after recovery
        base = tx_total;
        start_cmd(6'd17, 32'h0, 2'd0);
        wait_done("cmd17", n);
        check("cmd17_frame", 64'(tx_frame), 64'h510000000055);
        check("cmd17_oe_bits", 64'(tx_total - base), 64'd48);
        check("cmd17_errs", 64'({err_timeout, err_crc, err_index}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
